// File: rtl/key_press_classifier.sv
// Pushbutton front end: sync, debounce, hold timing, press classification.
// Emits a one-cycle press_valid on release and latches mode for the shifter.
module key_press_classifier #(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned TICK_DIV     = 5_000_000,
  parameter int unsigned MEDIUM_TICKS = 30,
  parameter int unsigned LONG_TICKS   = 50
) (
  input  logic       CLOCK_50Mhz,
  input  logic       RESET_N,
  input  logic       KEY_N,
  output logic       pressed,
  output logic [7:0] hold_ticks,
  output logic       press_valid,
  output logic [1:0] press_class,
  output logic [1:0] mode
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [8:0]    MED_T     = 9'(MEDIUM_TICKS);
  localparam logic [8:0]    LONG_T    = 9'(LONG_TICKS);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESSED = 1'b1;

  localparam logic [1:0] CLS_SHORT = 2'b00;
  localparam logic [1:0] CLS_MED   = 2'b01;
  localparam logic [1:0] CLS_LONG  = 2'b10;

  logic          key_s1;
  logic          key_s2;
  logic          deb_level;
  logic [DW-1:0] deb_cnt;
  logic [0:0]    state;
  logic [PW-1:0] presc;
  logic [1:0]    cls;
  logic [8:0]    hold9;

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= KEY_N;
      key_s2 <= key_s1;
    end
  end

  // Level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (key_s2 == deb_level) begin
      deb_cnt   <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_level <= key_s2;
      deb_cnt   <= '0;
    end else begin
      deb_cnt   <= deb_cnt + 1'b1;
    end
  end

  assign pressed = ~deb_level;
  assign hold9   = {1'b0, hold_ticks};

  always_comb begin
    cls = CLS_SHORT;
    unique case (1'b1)
      (hold9 >= LONG_T):                  cls = CLS_LONG;
      (hold9 >= MED_T && hold9 < LONG_T): cls = CLS_MED;
      (hold9 < MED_T):                    cls = CLS_SHORT;
      default:                            cls = CLS_SHORT;
    endcase
  end

  // A tick wrap on the release edge is dropped: release wins.
  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      presc       <= '0;
      hold_ticks  <= '0;
      press_valid <= 1'b0;
      press_class <= CLS_SHORT;
      mode        <= CLS_SHORT;
    end else begin
      press_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pressed) begin
            state      <= S_PRESSED;
            presc      <= '0;
            hold_ticks <= '0;
          end
        end
        S_PRESSED: begin
          if (!pressed) begin
            state       <= S_IDLE;
            press_valid <= 1'b1;
            press_class <= cls;
            mode        <= cls;
          end else if (presc == TICK_LAST) begin
            presc <= '0;
            if (hold_ticks != 8'hFF)
              hold_ticks <= hold_ticks + 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomised bench for key_press_classifier against a timestamp-based
// model: press length from debounced edges, classified with plain arithmetic.
module tb_key_press_classifier;

  localparam int DEB = 4;
  localparam int TD  = 10;
  localparam int MED = 3;
  localparam int LNG = 5;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       KEY_N;
  logic       pressed;
  logic [7:0] hold_ticks;
  logic       press_valid;
  logic [1:0] press_class;
  logic [1:0] mode;

  key_press_classifier #(
    .DEB_CYCLES  (DEB),
    .TICK_DIV    (TD),
    .MEDIUM_TICKS(MED),
    .LONG_TICKS  (LNG)
  ) dut (
    .CLOCK_50Mhz(clk),
    .RESET_N    (RESET_N),
    .KEY_N      (KEY_N),
    .pressed    (pressed),
    .hold_ticks (hold_ticks),
    .press_valid(press_valid),
    .press_class(press_class),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic       m1, m2, mlev;
  logic       win [DEB];
  int         since;
  bit         active;
  int         p_edge;
  int         exp_valid;
  int         exp_hold;
  logic [1:0] exp_class;
  logic [1:0] mmode;
  int         exp_nvalid;

  int         nvalid;
  int         pmis;
  int         vmis;
  int         rise_cyc;
  logic       prev_pressed;
  logic [7:0] cap_hold;
  logic [1:0] cap_class;
  logic [1:0] cap_mode;

  function automatic logic [1:0] cls_of(input int h);
    if (h >= LNG) return 2'b10;
    if (h >= MED) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m1 = 1'b1;
    m2 = 1'b1;
    mlev = 1'b1;
    for (int i = 0; i < DEB; i++) win[i] = 1'b1;
    since = 0;
    active = 1'b0;
    exp_valid = -1;
    mmode = 2'b00;
  endtask

  task automatic model_edge(input logic k);
    logic din;
    bit all_diff;
    din = m2;
    m2 = m1;
    m1 = k;
    for (int i = DEB - 1; i > 0; i--) win[i] = win[i-1];
    win[0] = din;
    since++;
    if (cyc == exp_valid) mmode = exp_class;
    all_diff = 1'b1;
    for (int i = 0; i < DEB; i++)
      if (win[i] == mlev) all_diff = 1'b0;
    if (since >= DEB && all_diff) begin
      mlev = !mlev;
      since = 0;
      if (!mlev) begin
        active = 1'b1;
        p_edge = cyc;
      end else if (active) begin
        active = 1'b0;
        exp_hold = (cyc - p_edge - 1) / TD;
        if (exp_hold > 255) exp_hold = 255;
        exp_class = cls_of(exp_hold);
        exp_valid = cyc + 1;
        exp_nvalid++;
      end
    end
  endtask

  task automatic clear_obs();
    nvalid = 0;
    pmis = 0;
    vmis = 0;
    rise_cyc = -1;
    exp_nvalid = 0;
  endtask

  task automatic step(input logic k);
    KEY_N = k;
    @(posedge clk);
    cyc++;
    if (!RESET_N) model_reset();
    else model_edge(k);
    #1;
    if (pressed === 1'b1 && prev_pressed !== 1'b1) rise_cyc = cyc;
    prev_pressed = pressed;
    if (pressed !== !mlev) pmis++;
    if (press_valid !== (cyc == exp_valid)) vmis++;
    if (press_valid === 1'b1) begin
      nvalid++;
      cap_hold = hold_ticks;
      cap_class = press_class;
      cap_mode = mode;
    end
  endtask

  task automatic press(input int low_n, input int bounce);
    for (int i = 0; i < bounce; i++) step((i % 2) == 0 ? 1'b0 : 1'b1);
    for (int i = 0; i < low_n; i++) step(1'b0);
    for (int i = 0; i < bounce; i++) step((i % 2) == 0 ? 1'b1 : 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    KEY_N = 1'b1;
    model_reset();
    clear_obs();
    for (int i = 0; i < 3; i++) step(1'b1);
    checks++;
    if ({pressed, hold_ticks, press_valid, press_class, mode} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {pressed, hold_ticks, press_valid, press_class, mode});
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1);
    checks++;
    if (pmis != 0 || nvalid != 0) begin
      fails++;
      $display("FAIL reset_idle: pmis=%0d nvalid=%0d expected 0 0", pmis, nvalid);
    end
  endtask

  task automatic test_short();
    int first_low;
    clear_obs();
    first_low = cyc + 1;
    press(25, 0);
    checks++;
    if (rise_cyc != first_low + 5) begin
      fails++;
      $display("FAIL short_rise: got edge %0d expected %0d", rise_cyc - first_low + 1, 6);
    end
    checks++;
    if (nvalid != 1 || vmis != 0 || pmis != 0) begin
      fails++;
      $display("FAIL short_valid: nvalid=%0d vmis=%0d pmis=%0d expected 1 0 0",
               nvalid, vmis, pmis);
    end
    checks++;
    if (cap_hold !== 8'd2 || cap_class !== 2'b00 || cap_mode !== 2'b00) begin
      fails++;
      $display("FAIL short_result: got %0d/%0d/%0d expected 2/0/0",
               cap_hold, cap_class, cap_mode);
    end
    checks++;
    if (hold_ticks !== 8'd2 || press_class !== 2'b00) begin
      fails++;
      $display("FAIL short_hold_kept: got %0d/%0d expected 2/0", hold_ticks, press_class);
    end
  endtask

  task automatic test_medium();
    clear_obs();
    press(35, 0);
    checks++;
    if (nvalid != 1 || vmis != 0 || pmis != 0) begin
      fails++;
      $display("FAIL medium_valid: nvalid=%0d vmis=%0d pmis=%0d expected 1 0 0",
               nvalid, vmis, pmis);
    end
    checks++;
    if (cap_hold !== 8'd3 || cap_class !== 2'b01 || mode !== 2'b01) begin
      fails++;
      $display("FAIL medium_result: got %0d/%0d/%0d expected 3/1/1",
               cap_hold, cap_class, mode);
    end
  endtask

  task automatic test_long_bounce();
    clear_obs();
    press(60, 3);
    checks++;
    if (nvalid != 1 || vmis != 0 || pmis != 0) begin
      fails++;
      $display("FAIL long_valid: nvalid=%0d vmis=%0d pmis=%0d expected 1 0 0",
               nvalid, vmis, pmis);
    end
    checks++;
    if (cap_hold !== 8'd6 || cap_class !== 2'b10 || mode !== 2'b10) begin
      fails++;
      $display("FAIL long_result: got %0d/%0d/%0d expected 6/2/2",
               cap_hold, cap_class, mode);
    end
  endtask

  task automatic test_glitch();
    logic [1:0] mode_before;
    mode_before = mode;
    clear_obs();
    press(3, 0);
    checks++;
    if (rise_cyc != -1 || nvalid != 0 || pmis != 0) begin
      fails++;
      $display("FAIL glitch: rise=%0d nvalid=%0d pmis=%0d expected -1 0 0",
               rise_cyc, nvalid, pmis);
    end
    checks++;
    if (mode !== mode_before) begin
      fails++;
      $display("FAIL glitch_mode: got %0d expected %0d", mode, mode_before);
    end
  endtask

  task automatic test_saturation();
    clear_obs();
    for (int i = 0; i < 3000; i++) step(1'b0);
    checks++;
    if (hold_ticks !== 8'd255) begin
      fails++;
      $display("FAIL sat_live: got %0d expected 255", hold_ticks);
    end
    for (int i = 0; i < 16; i++) step(1'b1);
    checks++;
    if (nvalid != 1 || cap_hold !== 8'd255 || cap_class !== 2'b10 || vmis != 0) begin
      fails++;
      $display("FAIL sat_result: nvalid=%0d hold=%0d class=%0d vmis=%0d expected 1 255 2 0",
               nvalid, cap_hold, cap_class, vmis);
    end
  endtask

  task automatic test_reset_mid_press();
    clear_obs();
    press(35, 0);
    checks++;
    if (mode !== 2'b01) begin
      fails++;
      $display("FAIL rst_pre_mode: got %0d expected 1", mode);
    end
    clear_obs();
    for (int i = 0; i < 20; i++) step(1'b0);
    RESET_N = 1'b0;
    step(1'b0);
    step(1'b0);
    checks++;
    if ({pressed, hold_ticks, press_valid, press_class, mode} !== 14'd0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {pressed, hold_ticks, press_valid, press_class, mode});
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 18; i++) step(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1);
    checks++;
    if (nvalid != 1 || vmis != 0 || pmis != 0) begin
      fails++;
      $display("FAIL rst_repress_valid: nvalid=%0d vmis=%0d pmis=%0d expected 1 0 0",
               nvalid, vmis, pmis);
    end
    checks++;
    if (cap_hold !== 8'd1 || cap_class !== 2'b00 || mode !== 2'b00) begin
      fails++;
      $display("FAIL rst_repress_result: got %0d/%0d/%0d expected 1/0/0",
               cap_hold, cap_class, mode);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    for (int i = 0; i < 40; i++) step(1'b0);
    for (int i = 0; i < 7; i++) step(1'b1);
    for (int i = 0; i < 12; i++) step(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1);
    checks++;
    if (nvalid != 2 || exp_nvalid != 2 || vmis != 0 || pmis != 0) begin
      fails++;
      $display("FAIL b2b: nvalid=%0d vmis=%0d pmis=%0d expected 2 0 0",
               nvalid, vmis, pmis);
    end
    checks++;
    if (cap_hold !== 8'(exp_hold) || cap_class !== 2'b00) begin
      fails++;
      $display("FAIL b2b_last: got %0d/%0d expected %0d/0", cap_hold, cap_class, exp_hold);
    end
  endtask

  task automatic test_random();
    int low_n;
    int bnc;
    for (int n = 0; n < 8; n++) begin
      low_n = int'($urandom_range(6, 70));
      bnc = int'($urandom_range(0, 3));
      clear_obs();
      press(low_n, bnc);
      checks++;
      if (nvalid != exp_nvalid || vmis != 0 || pmis != 0) begin
        fails++;
        $display("FAIL rand_valid[%0d]: nvalid=%0d vmis=%0d pmis=%0d expected %0d 0 0",
                 n, nvalid, vmis, pmis, exp_nvalid);
      end
      checks++;
      if (cap_hold !== 8'(exp_hold) || cap_class !== exp_class || mode !== mmode) begin
        fails++;
        $display("FAIL rand_result[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 n, cap_hold, cap_class, mode, exp_hold, exp_class, mmode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_medium();
    test_long_bounce();
    test_glitch();
    test_saturation();
    test_reset_mid_press();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
